// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 op codes,
// controller state encoding and width-derived constants.
package mdu_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    localparam logic [MDU_DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(MDU_DATA_WIDTH-1){1'b0}}};
    localparam logic [MDU_DATA_WIDTH-1:0] ALL_ONES = {MDU_DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Shared 2W-bit accumulator for radix-2 shift-add multiply and restoring divide.
// Upper half is product-high / partial remainder, lower half is multiplier / quotient.
module mdu_datapath #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           iter_i,
    input  logic           is_div_i,
    input  logic [W-1:0]   lo_init_i,
    input  logic [W-1:0]   opnd_i,
    output logic [2*W-1:0] acc_next_o
);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W-1:0]   diff;
    logic           canSub;

    assign hi      = acc_q[2*W-1:W];
    assign lo      = acc_q[W-1:0];
    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign shifted = {hi, lo[W-1]};
    assign canSub  = shifted >= {1'b0, opnd_q};
    // When canSub holds the difference is below the divisor, so W bits suffice.
    assign diff    = shifted[W-1:0] - opnd_q;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{W{1'b0}}, lo_init_i};
        end else if (iter_i) begin
            if (is_div_i) begin
                acc_d = canSub ? {diff, lo[W-2:0], 1'b1}
                               : {shifted[W-1:0], lo[W-2:0], 1'b0};
            end else begin
                acc_d = {sum, lo[W-1:1]};
            end
        end
    end

    assign acc_next_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opnd_q <= opnd_i;
            end
        end
    end

endmodule

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: W-cycle magnitude datapath with sign
// correction on the way into DONE; divide-by-zero and signed overflow finish in one edge.
module riscv_mdu
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            mdu_op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG_W = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES_W = {W{1'b1}};

    mdu_state_e           state_q;
    mdu_op_e              op_q;
    logic                 negA_q;
    logic                 negB_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [W-1:0]         result_q;

    mdu_op_e        opIn;
    logic           signedA;
    logic           signedB;
    logic           signA;
    logic           signB;
    logic [W-1:0]   magA;
    logic [W-1:0]   magB;
    logic           divZero;
    logic           overflow;
    logic           special;
    logic [W-1:0]   specialRes;
    logic           accept;
    logic [2*W-1:0] accNext;
    logic [2*W-1:0] prodFix;
    logic [W-1:0]   quoFix;
    logic [W-1:0]   remFix;
    logic [W-1:0]   finalRes;

    assign opIn     = mdu_op_e'(mdu_op);
    assign signedA  = (opIn == MDU_MULH) || (opIn == MDU_MULHSU) || (opIn == MDU_DIV) || (opIn == MDU_REM);
    assign signedB  = (opIn == MDU_MULH) || (opIn == MDU_DIV) || (opIn == MDU_REM);
    assign signA    = signedA && operand_a[W-1];
    assign signB    = signedB && operand_b[W-1];
    assign magA     = signA ? -operand_a : operand_a;
    assign magB     = signB ? -operand_b : operand_b;
    assign divZero  = mdu_op[2] && (operand_b == '0);
    assign overflow = ((opIn == MDU_DIV) || (opIn == MDU_REM)) &&
                      (operand_a == MOST_NEG_W) && (operand_b == ALL_ONES_W);
    assign special  = divZero || overflow;
    assign accept   = (state_q == IDLE) && start && !flush;

    // mdu_op[1] separates the remainder ops from the quotient ops within the divide group.
    always_comb begin
        specialRes = '0;
        if (divZero) begin
            specialRes = mdu_op[1] ? operand_a : ALL_ONES_W;
        end else if (overflow) begin
            specialRes = mdu_op[1] ? '0 : MOST_NEG_W;
        end
    end

    mdu_datapath #(.W(W)) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .iter_i     (state_q == CALC),
        .is_div_i   (op_q[2]),
        .lo_init_i  (mdu_op[2] ? magA : magB),
        .opnd_i     (mdu_op[2] ? magB : magA),
        .acc_next_o (accNext)
    );

    assign prodFix = (negA_q ^ negB_q) ? -accNext : accNext;
    assign quoFix  = (negA_q ^ negB_q) ? -accNext[W-1:0] : accNext[W-1:0];
    assign remFix  = negA_q ? -accNext[2*W-1:W] : accNext[2*W-1:W];

    always_comb begin
        case (op_q)
            MDU_MUL:           finalRes = prodFix[W-1:0];
            MDU_DIV, MDU_DIVU: finalRes = quoFix;
            MDU_REM, MDU_REMU: finalRes = remFix;
            default:           finalRes = prodFix[2*W-1:W];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            negA_q   <= 1'b0;
            negB_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q   <= opIn;
                        negA_q <= signA;
                        negB_q <= signB;
                        cnt_q  <= '0;
                        if (special) begin
                            result_q <= specialRes;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(W-1)) begin
                        result_q <= finalRes;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed testbench for riscv_mdu: arithmetic vectors, latency, special cases,
// flush, reset abort and back-to-back issue, all against hand-computed values.
module tb_riscv_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   mdu_op = 3'b000;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_mdu #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .mdu_op    (mdu_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one op, scrambles the inputs once it is accepted, and waits (bounded) for done.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit holdStart, output logic [W-1:0] res, output int edges,
                                 output logic busyGood, output logic busyAtDone, output logic doneAfter,
                                 output logic [W-1:0] resAfter);
        start = 1'b1;
        mdu_op = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        mdu_op = op ^ 3'b100;
        operand_a = ~a;
        operand_b = ~b;
        edges = 1;
        busyGood = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1) busyGood = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        res = result;
        busyAtDone = busy;
        @(posedge clk); #1;
        doneAfter = done;
        resAfter = result;
    endtask

    task automatic runCheck(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit holdStart,
                            input logic [W-1:0] expRes, input int expEdges);
        logic [W-1:0] res;
        logic [W-1:0] resAfter;
        int           edges;
        logic         busyGood;
        logic         busyAtDone;
        logic         doneAfter;
        applyStimulus(op, a, b, holdStart, res, edges, busyGood, busyAtDone, doneAfter, resAfter);
        checkOutput($sformatf("%s/result", tag), res, expRes);
        checkOutput($sformatf("%s/latency", tag), W'(edges), W'(expEdges));
        checkOutput($sformatf("%s/busyWhileCalc", tag), W'(busyGood), W'(1));
        checkOutput($sformatf("%s/busyAtDone", tag), W'(busyAtDone), W'(0));
        checkOutput($sformatf("%s/donePulseWidth", tag), W'(doneAfter), W'(0));
        checkOutput($sformatf("%s/resultHold", tag), resAfter, expRes);
    endtask

    initial begin
        bit sawDone;

        #1 rst_n = 1'b0;
        #20;
        checkOutput("reset/busy", W'(busy), W'(0));
        checkOutput("reset/done", W'(done), W'(0));
        checkOutput("reset/result", result, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        runCheck("mul",      MDU_MUL,    32'd7,         32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 33);
        runCheck("mulhNeg",  MDU_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 33);
        runCheck("mulhuBig", MDU_MULHU,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 33);
        runCheck("mulhsu",   MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 33);
        runCheck("mulhM1",   MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 33);
        runCheck("mulhuM1",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 33);
        runCheck("mulZero",  MDU_MUL,    32'd0,         32'd12345,     1'b0, 32'd0,         33);

        runCheck("div",      MDU_DIV,    32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 33);
        runCheck("rem",      MDU_REM,    32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 33);
        runCheck("divu",     MDU_DIVU,   32'd100,       32'd7,         1'b0, 32'd14,        33);
        runCheck("remu",     MDU_REMU,   32'd100,       32'd7,         1'b0, 32'd2,         33);
        runCheck("divNegB",  MDU_DIV,    32'd20,        32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFA, 33);
        runCheck("remNegB",  MDU_REM,    32'd20,        32'hFFFF_FFFD, 1'b0, 32'd2,         33);
        runCheck("divMinBy2", MDU_DIV,   32'h8000_0000, 32'd2,         1'b0, 32'hC000_0000, 33);

        runCheck("divuBy0",  MDU_DIVU,   32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 1);
        runCheck("remBy0",   MDU_REM,    32'd5,         32'd0,         1'b0, 32'd5,         1);
        runCheck("divOvf",   MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1);
        runCheck("remOvf",   MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         1);

        runCheck("holdStart", MDU_MUL,   32'd7,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 33);
        checkOutput("holdStart/idleAfter", W'(busy), W'(0));

        // Flush raised after edge 10 of a DIV, sampled on edge 11.
        start = 1'b1; mdu_op = MDU_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush/busy", W'(busy), W'(0));
        checkOutput("flush/done", W'(done), W'(0));
        checkOutput("flush/result", result, 32'hFFFF_FFEB);
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("flush/noLateDone", W'(sawDone), W'(0));
        checkOutput("flush/resultKept", result, 32'hFFFF_FFEB);

        start = 1'b1; flush = 1'b1; mdu_op = MDU_DIVU; operand_a = 32'd5; operand_b = 32'd0;
        @(posedge clk); #1;
        checkOutput("startFlushSpecial/done", W'(done), W'(0));
        checkOutput("startFlushSpecial/result", result, 32'hFFFF_FFEB);
        mdu_op = MDU_MUL; operand_a = 32'd3; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("startFlushNormal/busy", W'(busy), W'(0));

        start = 1'b1; mdu_op = MDU_MUL; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset/busy", W'(busy), W'(0));
        checkOutput("midReset/done", W'(done), W'(0));
        checkOutput("midReset/result", result, '0);
        @(negedge clk) rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("midReset/noDone", W'(sawDone), W'(0));

        runCheck("b2bFirst",  MDU_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 33);
        runCheck("b2bSecond", MDU_REMU, 32'd100, 32'd7, 1'b0, 32'd2,  33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
